// File: rtl/display_scan_decoder.sv
// display_scan_decoder: recovers BCD time frames from a scanned
// 7-segment display, with stability filtering and scan-loss timeout.
module display_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [6:0]  display_out,
  input  logic [3:0]  segment_digit,
  output logic [15:0] digits,
  output logic [3:0]  blank_mask,
  output logic [3:0]  err_mask,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        scan_lost
);

  localparam logic [3:0]  STABLE_W = 4'(STABLE_CYCLES);
  localparam logic [15:0] TO_W     = 16'(TIMEOUT_CYCLES);

  logic [3:0]       sel_q, sel_d;
  logic [6:0]       pat_q, pat_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [3:0][3:0]  stage_val_q, stage_val_d;
  logic [3:0]       stage_blank_q, stage_blank_d;
  logic [3:0]       stage_err_q, stage_err_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       blank_q, blank_d;
  logic [3:0]       err_q, err_d;
  logic             fv_q, fv_d;
  logic             fc_q, fc_d;
  logic [15:0]      to_q, to_d;
  logic             lost_q, lost_d;
  logic             first_q, first_d;

  logic             onehot;
  logic             same;
  logic             done;
  logic [3:0]       dec_val;
  logic             dec_blank;
  logic             dec_err;

  // Run tracking looks at the sample being registered against the
  // current registered copy, so an accept lands on the S-th sample edge.
  always_comb begin
    sel_d  = segment_digit;
    pat_d  = display_out;
    onehot = (segment_digit != 4'd0) &&
             ((segment_digit & (segment_digit - 4'd1)) == 4'd0);
    same   = (segment_digit == sel_q) && (display_out == pat_q);
    cnt_d  = 4'd0;
    acc_d  = 1'b0;
    if (onehot) begin
      if (!same) begin
        cnt_d = 4'd1;
      end else if (cnt_q != 4'd15) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d = cnt_q;
      end
      acc_d = same ? (cnt_q == STABLE_W - 4'd1)
                   : (STABLE_W == 4'd1);
    end
  end

  always_comb begin
    dec_val   = 4'hE;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (pat_q)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110000: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1111011: dec_val = 4'd9;
      7'b0000000: begin
        dec_val   = 4'hF;
        dec_blank = 1'b1;
      end
      default:    dec_err = 1'b1;
    endcase
  end

  always_comb begin
    stage_val_d   = stage_val_q;
    stage_blank_d = stage_blank_q;
    stage_err_d   = stage_err_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    blank_d       = blank_q;
    err_d         = err_q;
    first_d       = first_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q && sel_q[i]) begin
        stage_val_d[i]   = dec_val;
        stage_blank_d[i] = dec_blank;
        stage_err_d[i]   = dec_err;
        seen_d[i]        = 1'b1;
      end
    end
    done = &seen_d;
    fv_d = done;
    if (done) begin
      digits_d = stage_val_d;
      blank_d  = stage_blank_d;
      err_d    = stage_err_d;
      seen_d   = 4'd0;
      first_d  = 1'b0;
    end
    fc_d = done && (first_q ||
           ({digits_d, blank_d, err_d} != {digits_q, blank_q, err_q}));
    // A completing frame beats a coincident timeout.
    if (done) begin
      to_d   = 16'd0;
      lost_d = 1'b0;
    end else begin
      to_d   = (to_q == 16'hFFFF) ? to_q : to_q + 16'd1;
      lost_d = lost_q || (to_d == TO_W);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sel_q         <= 4'd0;
      pat_q         <= 7'd0;
      cnt_q         <= 4'd0;
      acc_q         <= 1'b0;
      stage_val_q   <= '0;
      stage_blank_q <= 4'd0;
      stage_err_q   <= 4'd0;
      seen_q        <= 4'd0;
      digits_q      <= 16'hFFFF;
      blank_q       <= 4'hF;
      err_q         <= 4'h0;
      fv_q          <= 1'b0;
      fc_q          <= 1'b0;
      to_q          <= 16'd0;
      lost_q        <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      sel_q         <= sel_d;
      pat_q         <= pat_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      stage_val_q   <= stage_val_d;
      stage_blank_q <= stage_blank_d;
      stage_err_q   <= stage_err_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      fv_q          <= fv_d;
      fc_q          <= fc_d;
      to_q          <= to_d;
      lost_q        <= lost_d;
      first_q       <= first_d;
    end
  end

  assign digits        = digits_q;
  assign blank_mask    = blank_q;
  assign err_mask      = err_q;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign scan_lost     = lost_q;

endmodule

// File: doc/display_scan_decoder.md
# display_scan_decoder

Receive-side companion of the alarm-clock datapath's multiplexed 7-segment output. It samples the scanned `display_out`/`segment_digit` pair and requires each digit pattern to hold stable before accepting it. Accepted patterns are decoded back to BCD and assembled into a complete four-digit frame with blank and error flags. It sits beside the datapath in board-level checking and self-test logic, turning the scan back into numeric time/alarm values.

## Interface
- `STABLE_CYCLES`, 2: consecutive identical samples required to accept a digit (legal range 1–15).
- `TIMEOUT_CYCLES`, 1024: cycles without a completed frame before `scan_lost` asserts (legal range 2–65535).

Ports (one clock domain; reset is synchronous, active-low):
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-low reset.
- `display_out`  in  7  segment pattern {a,b,c,d,e,f,g} at [6:0], active-high.
- `segment_digit`  in  4  one-hot, active-high digit select; bit0 = minutes units, bit1 = minutes tens, bit2 = hours units, bit3 = hours tens.
- `digits`  out  16  accepted frame as BCD {d3,d2,d1,d0}, 4 bits each.
- `blank_mask`  out  4  per-digit flag: 1 = digit was blank in the frame.
- `err_mask`  out  4  per-digit flag: 1 = pattern was not a legal glyph.
- `frame_valid`  out  1  one-cycle pulse when `digits`/`blank_mask`/`err_mask` update.
- `frame_changed`  out  1  one-cycle pulse, coincident with `frame_valid`, when the new frame differs from the previous one in any field.
- `scan_lost`  out  1  level; no frame completed within `TIMEOUT_CYCLES`.

## Operation
- **Input register:** `display_out` and `segment_digit` are registered once; all logic operates on the registered copy.
- **Stability tracking:** a 4-bit counter tracks runs of identical registered {select, pattern}.
  - The counter resets to 1 when either value changes.
  - The counter also resets when the select is not one-hot (zero or multi-hot). Such samples are ignored.
  - A digit is accepted when the run length reaches `STABLE_CYCLES`. Each run is accepted exactly once, and the counter saturates.
- **Decode table** (pattern -> value):
  - 7'b1111110 -> 0
  - 7'b0110000 -> 1
  - 7'b1101101 -> 2
  - 7'b1111001 -> 3
  - 7'b0110011 -> 4
  - 7'b1011011 -> 5
  - 7'b1011111 -> 6
  - 7'b1110000 -> 7
  - 7'b1111111 -> 8
  - 7'b1111011 -> 9
  - 7'b0000000 -> value 4'hF, blank = 1.
  - Any other pattern -> value 4'hE, err = 1.
- **Staging:** each accept writes the decoded value, blank flag and err flag into the staging slot for that digit and sets the digit's `seen` bit. Re-accepting a digit before the frame completes overwrites its slot (latest wins).
- **Frame completion:** when all four `seen` bits are set, the staging contents are copied to the outputs, `frame_valid` pulses, and `seen` clears.
- **`frame_changed`:** asserts with `frame_valid` only when {digits, blank_mask, err_mask} differs from the previous output value. The first frame after reset always raises `frame_changed`.
- **Timeout:** a 16-bit counter clears on `frame_valid` and otherwise increments, saturating.
  - `scan_lost` sets when the counter reaches `TIMEOUT_CYCLES`.
  - `scan_lost` clears on the next `frame_valid`.
- **Blinking:** blanking from the datapath's blink (`dblink`) is not an error. It produces frames with `blank_mask` bits set.

## Timing
- **Reset values** (while `Reset`=0 at a clock edge):
  - `digits` = 16'hFFFF, `blank_mask` = 4'hF, `err_mask` = 4'h0.
  - `frame_valid` = 0, `frame_changed` = 0, `scan_lost` = 0.
  - All counters, staging slots and `seen` bits cleared.
- **Reset mid-frame:** discards partial staging. No `frame_valid` is produced from pre-reset samples.
- **Accept latency:** an input stable from edge k is registered at k. Its accept occurs on the edge at which the `STABLE_CYCLES`-th identical sample is registered, i.e. edge k + `STABLE_CYCLES` − 1.
- **Frame latency:** `frame_valid` rises at the edge following the accept of the last outstanding digit. It is high for exactly one cycle.
- **Simultaneous events:**
  - Frame completion and timeout in the same cycle: the completion wins, so the counter clears and `scan_lost` stays/becomes 0.
  - Accept in the cycle `frame_valid` is high: the accept counts toward the next frame.
- **Wrap-around:** the timeout counter saturates at 16'hFFFF and never wraps. The stability counter saturates at 15.

## Test plan
1. **Reset:** `Reset`=0 for 3 cycles -> `digits`=16'hFFFF, `blank_mask`=4'hF, `err_mask`=0, `scan_lost`=0, no pulses.
2. **Clean scan, `STABLE_CYCLES`=2:** each digit is held 4 cycles, showing 1,2,3,0 on bits3..0 (12:30).
   - `frame_valid` and `frame_changed` pulse one cycle after the bit3 accept.
   - `digits`=16'h1230, masks 0.
   - An identical second scan gives `frame_valid`=1 with `frame_changed`=0.
3. **Glitch rejection:** a 1-cycle pattern 7'b0110000 on digit0 precedes a stable 7'b1111110 -> digit0 decodes 0 and the glitch is never accepted. A select of 4'b0011 for 5 cycles -> no accept.
4. **Blank/error:** digit2 shows 7'b0000000 and digit1 shows 7'b1000001 -> `blank_mask`=4'b0100, `err_mask`=4'b0010, `digits`[11:8]=F, `digits`[7:4]=E.
5. **Timeout:** with `TIMEOUT_CYCLES`=16 and no scan after one frame, `scan_lost`=1 on the 16th cycle after that `frame_valid`. It clears on the next completed frame.
6. **Reset mid-frame:** after digits 0–2 are accepted, `Reset`=0 for one cycle, then only digit3 is scanned -> no `frame_valid` until all four digits are rescanned.
